bcd_excess3_seq_ctrl: RTL and testbench
=======================================

# bcd_excess3_seq_ctrl

Sequenced multi-digit BCD-to-excess-3 converter controller. It accepts a packed NDIG-digit BCD word over a valid/ready handshake and converts one digit per cycle, least-significant digit first, through a single shared per-digit converter. It flags non-BCD digits and presents the packed excess-3 word with valid/ready backpressure. It sits between a BCD source (keypad/counter front end) and any excess-3 consumer (self-complementing adder, display path).

## Interface
- NDIG, default 4: number of BCD digits per word (≥1).
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source has a word on in_bcd.
- in_ready  out  1  controller can accept a word.
- in_bcd  in  4*NDIG  packed BCD; digit i at bits [4i+3:4i].
- out_valid  out  1  out_xs3/out_err/out_err_mask hold a result.
- out_ready  in  1  consumer takes the result.
- out_xs3  out  4*NDIG  packed excess-3 result, same digit layout.
- out_err  out  1  OR of out_err_mask.
- out_err_mask  out  NDIG  bit i set if input digit i was > 9.

## Operation
- FSM states: IDLE, CONV, DONE. Reset state is IDLE.
- IDLE: in_ready=1. When in_valid&&in_ready, capture in_bcd into an input register, clear the result register and err mask, set digit index idx=0, then go to CONV.
- CONV: in_ready=0, out_valid=0. Each cycle:
  - Take digit d = input[idx].
  - If d ≤ 9: result[idx] = d+3, a 4-bit add with no overflow (max 9+3=12).
  - If d ∈ 10..15: result[idx] = 4'b0000 and err_mask[idx] = 1. The controller masks the value itself, independent of the sub-module's default for invalid codes.
  - Then idx += 1. When idx == NDIG-1 is processed, go to DONE. idx never wraps past NDIG-1.
- DONE: out_valid=1, and outputs are held stable. On out_valid&&out_ready, go to IDLE. A new word is not accepted in DONE; there is no overlap between words.
- in_valid while in CONV or DONE is ignored. The source must hold it, per the handshake rule.
- Result registers are not cleared on the DONE→IDLE transition. They keep their last value until the next accept clears them.

## Timing
- Reset values while rst=1 and in the cycle after: state=IDLE, in_ready=0 while rst=1 (then 1), out_valid=0, out_xs3=0, out_err=0, out_err_mask=0, idx=0.
- Reset mid-operation (CONV or DONE): abort, return to the reset values, discard the partial result. No out_valid is produced for the aborted word.
- Handshake: a transfer occurs on a rising edge where valid&&ready. Once asserted, valid must stay asserted with stable data until the transfer. out_valid obeys this rule.
- Latency: accept on edge E0 → digits processed on edges E1..E_NDIG → out_valid=1 from after edge E_NDIG.
- NDIG=1: a single CONV cycle.
- Minimum cycle per word: NDIG+2 (one IDLE accept cycle, NDIG CONV cycles, at least one DONE cycle).
- out_ready held low: DONE persists indefinitely with outputs unchanged.
- out_ready high on arrival in DONE: handshake completes in the first DONE cycle. in_ready=1 on the following cycle.
- All outputs are registered or decoded from state only. There is no combinational path from in_* to out_*.

## Structure
- Shared package bcd_xs3_pkg holds:
  - state enum {IDLE, CONV, DONE};
  - XS3_OFFSET=4'd3;
  - BCD_MAX=4'd9;
  - XS3_INVALID=4'b0000;
  - DIGIT_W=4.
- One sub-module: the existing combinational bcd_to_excess3 (bcd[3:0] → excess3[3:0]), instantiated once and fed by a mux on idx. The controller applies the validity check and the XS3_INVALID override.
- idx width is $clog2(NDIG), with a minimum of 1.

## Test plan
- NDIG=4, in_bcd=16'h1234, out_ready=1:
  - out_xs3=16'h4567, err=0, mask=4'b0000;
  - out_valid rises 4 cycles after accept;
  - in_ready returns 1 one cycle after the handshake.
- in_bcd=16'h9A05:
  - out_xs3=16'hC038, out_err_mask=4'b0100, out_err=1;
  - remaining digits convert normally.
- in_bcd=16'h0909 with out_ready=0 for 6 cycles in DONE:
  - out_xs3=16'h3C3C stays stable with out_valid=1;
  - in_ready=0 throughout;
  - a single transfer occurs when out_ready rises.
- Assert rst for one cycle after 2 CONV cycles of 16'h5678:
  - all outputs go to 0, no out_valid for that word;
  - the next word 16'h0000 yields 16'h3333 with err=0.
- Back-to-back words 16'h1111 then 16'h8765 with in_valid held:
  - second accepted exactly one cycle after the first output handshake;
  - results 16'h4444 and 16'hBA98.
- NDIG=1: in_bcd=4'hF gives out_xs3=4'h0 and out_err=1 after 1 cycle. in_bcd=4'h9 gives 4'hC.

Source files
------------

// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the sequenced BCD-to-excess-3 converter.
// Digit width, code limits and the controller state encoding live here.
package bcd_xs3_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] XS3_OFFSET  = 4'd3;
  localparam logic [DIGIT_W-1:0] BCD_MAX     = 4'd9;
  localparam logic [DIGIT_W-1:0] XS3_INVALID = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_to_excess3.sv
// Combinational single-digit BCD to excess-3 converter.
// Non-BCD codes map to all ones; callers that need another value override it.
module bcd_to_excess3
  import bcd_xs3_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [DIGIT_W-1:0] excess3
);

  always_comb begin
    excess3 = '1;
    if (is_bcd(bcd)) begin
      excess3 = bcd + XS3_OFFSET;
    end
  end

endmodule

// File: rtl/bcd_excess3_seq_ctrl.sv
// Multi-digit BCD to excess-3 controller: accepts a packed word, converts one digit
// per cycle LSD first through a shared converter, then holds the result for the consumer.
module bcd_excess3_seq_ctrl
  import bcd_xs3_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*NDIG-1:0] in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*NDIG-1:0] out_xs3,
  output logic                    out_err,
  output logic [NDIG-1:0]         out_err_mask
);

  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);

  state_e                         state_q, state_d;
  logic [NDIG-1:0][DIGIT_W-1:0]   in_q, in_d;
  logic [NDIG-1:0][DIGIT_W-1:0]   res_q, res_d;
  logic [NDIG-1:0]                mask_q, mask_d;
  logic [IdxW-1:0]                idx_q, idx_d;

  logic [DIGIT_W-1:0]             cur_digit;
  logic [DIGIT_W-1:0]             cur_xs3;

  assign cur_digit = in_q[idx_q];

  bcd_to_excess3 u_conv (
    .bcd     (cur_digit),
    .excess3 (cur_xs3)
  );

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    res_d   = res_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = in_bcd;
          res_d   = '0;
          mask_d  = '0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        // Invalid codes are forced here, whatever the shared converter emits for them.
        if (is_bcd(cur_digit)) begin
          res_d[idx_q] = cur_xs3;
        end else begin
          res_d[idx_q]  = XS3_INVALID;
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == LastIdx) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_q    <= '0;
      res_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      res_q   <= res_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
    end
  end

  // in_ready is held low during reset so nothing is taken while the block is cleared.
  assign in_ready     = (state_q == IDLE) && !rst;
  assign out_valid    = (state_q == DONE);
  assign out_xs3      = res_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;

  property p_out_hold;
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(res_q) && $stable(mask_q));
  endproperty
  a_out_hold: assert property (p_out_hold);

endmodule

// File: tb/tb_bcd_excess3_seq_ctrl.sv
// Self-checking bench: vector table, directed corner sequences, randomized words
// against an arithmetic reference model; also exercises a single-digit instance.
module tb_bcd_excess3_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_bcd, out_xs3;
  logic [3:0]  out_err_mask;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [3:0]  in_bcd1, out_xs3_1;
  logic [0:0]  out_err_mask1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_excess3_seq_ctrl #(.NDIG(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_xs3      (out_xs3),
    .out_err      (out_err),
    .out_err_mask (out_err_mask)
  );

  bcd_excess3_seq_ctrl #(.NDIG(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid1),
    .in_ready     (in_ready1),
    .in_bcd       (in_bcd1),
    .out_valid    (out_valid1),
    .out_ready    (out_ready1),
    .out_xs3      (out_xs3_1),
    .out_err      (out_err1),
    .out_err_mask (out_err_mask1)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [15:0] xs3;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each decimal digit plus three; any nibble above nine gives zero and an error bit.
  function automatic void ref_model(input logic [15:0] w, output logic [15:0] x,
                                    output logic [3:0] m);
    int d;
    x = '0;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      d = (int'(w) >> (4 * i)) % 16;
      if (d > 9) m[i] = 1'b1;
      else x = x | 16'((d + 3) << (4 * i));
    end
  endfunction

  // Present a word, wait for the accept, then count edges until out_valid.
  task automatic do_word(input logic [15:0] w, input logic ordy, output int lat);
    int n;
    in_bcd    = w;
    in_valid  = 1'b1;
    out_ready = ordy;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("accept_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_bcd   = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          k;
    logic [15:0] w, ex;
    logic [3:0]  em;

    vecs[0] = '{16'h1234, 16'h4567, 4'b0000};
    vecs[1] = '{16'h9A05, 16'hC038, 4'b0100};
    vecs[2] = '{16'h0909, 16'h3C3C, 4'b0000};
    vecs[3] = '{16'h0000, 16'h3333, 4'b0000};
    vecs[4] = '{16'h1111, 16'h4444, 4'b0000};
    vecs[5] = '{16'h8765, 16'hBA98, 4'b0000};
    vecs[6] = '{16'hFFFF, 16'h0000, 4'b1111};
    vecs[7] = '{16'hB9C9, 16'h0C0C, 4'b1010};

    rst = 1'b1;
    in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_bcd1 = '0; out_ready1 = 1'b0;

    // Reset values
    step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_xs3", out_xs3, 16'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_mask", out_err_mask, 4'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // Table-driven words with out_ready high
    for (int i = 0; i < 8; i++) begin
      do_word(vecs[i].bcd, 1'b1, lat);
      chk("tbl_latency", 32'(lat), 32'd4);
      chk("tbl_xs3", out_xs3, vecs[i].xs3);
      chk("tbl_mask", out_err_mask, vecs[i].mask);
      chk("tbl_err", out_err, |vecs[i].mask);
      step();
      chk("tbl_valid_drop", out_valid, 1'b0);
      chk("tbl_in_ready_back", in_ready, 1'b1);
    end

    // Backpressure: result held for 6 cycles
    do_word(16'h0909, 1'b0, lat);
    chk("hold_latency", 32'(lat), 32'd4);
    in_valid = 1'b1;
    in_bcd   = 16'h2222;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_xs3", out_xs3, 16'h3C3C);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold_release", out_valid, 1'b0);
    chk("hold_in_ready_back", in_ready, 1'b1);
    out_ready = 1'b0;
    step();
    chk("hold_single_xfer", out_valid, 1'b0);

    // Reset during conversion
    in_bcd = 16'h5678;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_xs3", out_xs3, 16'h0);
    chk("midrst_mask", out_err_mask, 4'h0);
    chk("midrst_valid", out_valid, 1'b0);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) k++;
    end
    chk("midrst_no_valid", 32'(k), 32'd0);
    do_word(16'h0000, 1'b1, lat);
    chk("midrst_next_xs3", out_xs3, 16'h3333);
    chk("midrst_next_err", out_err, 1'b0);
    step();

    // Back-to-back with in_valid held
    in_bcd = 16'h1111;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_bcd = 16'h8765;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("b2b_first_xs3", out_xs3, 16'h4444);
    step();
    chk("b2b_ready_after_hs", in_ready, 1'b1);
    step();
    chk("b2b_second_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("b2b_second_latency", 32'(lat), 32'd4);
    chk("b2b_second_xs3", out_xs3, 16'hBA98);
    step();
    out_ready = 1'b0;

    // Randomized words against the reference model, random consumer stalls
    for (int r = 0; r < 40; r++) begin
      w = '0;
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 3) == 0) w[4*d +: 4] = 4'($urandom_range(0, 15));
        else w[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      ref_model(w, ex, em);
      do_word(w, 1'b0, lat);
      chk("rnd_latency", 32'(lat), 32'd4);
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) step();
      chk("rnd_valid", out_valid, 1'b1);
      chk("rnd_xs3", out_xs3, ex);
      chk("rnd_mask", out_err_mask, em);
      chk("rnd_err", out_err, |em);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("rnd_done", out_valid, 1'b0);
    end

    // Single-digit instance
    in_bcd1 = 4'hF;
    in_valid1 = 1'b1;
    chk("n1_in_ready", in_ready1, 1'b1);
    step();
    in_valid1 = 1'b0;
    chk("n1_conv_valid", out_valid1, 1'b0);
    step();
    chk("n1_valid", out_valid1, 1'b1);
    chk("n1_xs3_f", out_xs3_1, 4'h0);
    chk("n1_err_f", out_err1, 1'b1);
    chk("n1_mask_f", out_err_mask1, 1'b1);
    out_ready1 = 1'b1;
    step();
    chk("n1_valid_drop", out_valid1, 1'b0);
    in_bcd1 = 4'h9;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    step();
    chk("n1_valid_9", out_valid1, 1'b1);
    chk("n1_xs3_9", out_xs3_1, 4'hC);
    chk("n1_err_9", out_err1, 1'b0);
    step();
    out_ready1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
